// File: rtl/nap_pkg.sv
// rtl/nap_pkg.sv - Shared state encoding, BCD limits and defaults for the nap timer
package nap_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_ALARM = 3'd4;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  localparam int TICKS_PER_SEC_DEF  = 1000;
  localparam int ALARM_SECONDS_DEF  = 30;
  localparam int SNOOZE_MINUTES_DEF = 5;

  // Returns {borrow_out, digit}; a digit at 0 with a borrow in wraps to dmax.
  function automatic logic [4:0] dec_digit(input logic [3:0] d, input logic [3:0] dmax,
                                           input logic bin);
    logic [4:0] r;
    if (!bin)
      r = {1'b0, d};
    else if (d == 4'd0)
      r = {1'b1, dmax};
    else
      r = {1'b0, d - 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// rtl/bcd_time_dec.sv - Combinational one-second decrement of a 6-digit BCD hh:mm:ss value
module bcd_time_dec
  import nap_pkg::*;
(
  input  logic [23:0] cur,
  output logic [23:0] nxt,
  output logic        is_one
);

  logic [4:0] s1_r, s10_r, m1_r, m10_r, h1_r;

  assign s1_r  = dec_digit(cur[3:0],   DIGIT_MAX, 1'b1);
  assign s10_r = dec_digit(cur[7:4],   TENS_MAX,  s1_r[4]);
  assign m1_r  = dec_digit(cur[11:8],  DIGIT_MAX, s10_r[4]);
  assign m10_r = dec_digit(cur[15:12], TENS_MAX,  m1_r[4]);
  assign h1_r  = dec_digit(cur[19:16], DIGIT_MAX, m10_r[4]);

  // Hour tens never needs to wrap: the caller stops at 00:00:01.
  assign nxt = {(h1_r[4] ? cur[23:20] - 4'd1 : cur[23:20]),
                h1_r[3:0], m10_r[3:0], m1_r[3:0], s10_r[3:0], s1_r[3:0]};

  assign is_one = (cur == 24'h000001);

endmodule

// File: rtl/nap_timer_ctrl.sv
// rtl/nap_timer_ctrl.sv - Nap countdown FSM: setup handshake, 1 Hz BCD countdown, pause, alarm and snooze
module nap_timer_ctrl
  import nap_pkg::*;
#(
  parameter int TICKS_PER_SEC  = TICKS_PER_SEC_DEF,
  parameter int ALARM_SECONDS  = ALARM_SECONDS_DEF,
  parameter int SNOOZE_MINUTES = SNOOZE_MINUTES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [9:0] keypad,
  input  logic       sharp,
  input  logic       star,
  input  logic       load,
  input  logic [3:0] iHour10,
  input  logic [3:0] iHour1,
  input  logic [3:0] iMinute10,
  input  logic [3:0] iMinute1,
  input  logic [3:0] iSecond10,
  input  logic [3:0] iSecond1,
  output logic [3:0] hour10,
  output logic [3:0] hour1,
  output logic [3:0] minute10,
  output logic [3:0] minute1,
  output logic [3:0] second10,
  output logic [3:0] second1,
  output logic       setup_en,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = (ALARM_SECONDS > 1) ? $clog2(ALARM_SECONDS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECONDS - 1);
  localparam logic [23:0]   SNOOZE_TIME = {12'h000, 4'(SNOOZE_MINUTES), 8'h00};

  logic [2:0]    state, state_n;
  logic [PW-1:0] presc, presc_n, presc_inc;
  logic [AW-1:0] alarm_cnt, alarm_cnt_n;
  logic [23:0]   time_q, time_n, time_dec, load_time;
  logic          done_n, tick, is_one, load_ok;
  logic          unused_keys;

  assign unused_keys = ^keypad[9:1];
  assign load_time   = {iHour10, iHour1, iMinute10, iMinute1, iSecond10, iSecond1};
  assign tick        = (presc == PRESC_LAST);
  assign presc_inc   = tick ? '0 : presc + 1'b1;

  assign load_ok = (iHour10 <= DIGIT_MAX) && (iHour1 <= DIGIT_MAX) &&
                   (iMinute10 <= TENS_MAX) && (iMinute1 <= DIGIT_MAX) &&
                   (iSecond10 <= TENS_MAX) && (iSecond1 <= DIGIT_MAX) &&
                   (load_time != 24'h0);

  bcd_time_dec u_dec (
    .cur    (time_q),
    .nxt    (time_dec),
    .is_one (is_one)
  );

  always_comb begin
    state_n     = state;
    presc_n     = presc;
    alarm_cnt_n = alarm_cnt;
    time_n      = time_q;
    done_n      = 1'b0;
    if (!en) begin
      state_n     = ST_IDLE;
      presc_n     = '0;
      alarm_cnt_n = '0;
      time_n      = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          presc_n = '0;
          time_n  = '0;
          if (sharp && !star) state_n = ST_SETUP;
        end
        ST_SETUP: begin
          if (star) begin
            state_n = ST_IDLE;
          end else if (!sharp && load && load_ok) begin
            time_n  = load_time;
            presc_n = '0;
            state_n = ST_RUN;
          end
        end
        ST_RUN: begin
          presc_n = presc_inc;
          if (star) begin
            state_n = ST_IDLE;
            presc_n = '0;
            time_n  = '0;
          end else begin
            // A tick coincident with '#' is applied before the pause takes effect.
            if (tick) begin
              if (is_one) begin
                time_n      = '0;
                done_n      = 1'b1;
                alarm_cnt_n = '0;
                state_n     = ST_ALARM;
              end else begin
                time_n = time_dec;
              end
            end
            if (sharp && !(tick && is_one)) state_n = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (star) begin
            state_n = ST_IDLE;
            presc_n = '0;
            time_n  = '0;
          end else if (sharp) begin
            state_n = ST_RUN;
          end
        end
        ST_ALARM: begin
          presc_n = presc_inc;
          if (star) begin
            state_n = ST_IDLE;
            presc_n = '0;
          end else if (!sharp && keypad[0]) begin
            time_n  = SNOOZE_TIME;
            presc_n = '0;
            state_n = ST_RUN;
          end else if (tick) begin
            if (alarm_cnt == ALARM_LAST) begin
              state_n = ST_IDLE;
              presc_n = '0;
            end else begin
              alarm_cnt_n = alarm_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          presc_n = '0;
          time_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      presc     <= '0;
      alarm_cnt <= '0;
      time_q    <= '0;
      setup_en  <= 1'b0;
      running   <= 1'b0;
      alarm     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      alarm_cnt <= alarm_cnt_n;
      time_q    <= time_n;
      setup_en  <= (state_n == ST_SETUP);
      running   <= (state_n == ST_RUN);
      alarm     <= (state_n == ST_ALARM);
      done      <= done_n;
    end
  end

  assign {hour10, hour1, minute10, minute1, second10, second1} = time_q;

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// tb/tb_nap_timer_ctrl.sv - Directed self-checking bench for nap_timer_ctrl
module tb_nap_timer_ctrl;

  logic       clock = 1'b0;
  logic       reset, en, sharp, star, load;
  logic [9:0] keypad;
  logic [3:0] iHour10, iHour1, iMinute10, iMinute1, iSecond10, iSecond1;
  logic [3:0] hour10, hour1, minute10, minute1, second10, second1;
  logic       setup_en, running, alarm, done;
  logic [23:0] time_out;
  int tests = 0;
  int failed = 0;

  assign time_out = {hour10, hour1, minute10, minute1, second10, second1};

  always #5 clock = ~clock;

  nap_timer_ctrl #(.TICKS_PER_SEC(4), .ALARM_SECONDS(30), .SNOOZE_MINUTES(5)) dut (
    .clock(clock), .reset(reset), .en(en), .keypad(keypad), .sharp(sharp), .star(star),
    .load(load), .iHour10(iHour10), .iHour1(iHour1), .iMinute10(iMinute10),
    .iMinute1(iMinute1), .iSecond10(iSecond10), .iSecond1(iSecond1),
    .hour10(hour10), .hour1(hour1), .minute10(minute10), .minute1(minute1),
    .second10(second10), .second1(second1), .setup_en(setup_en), .running(running),
    .alarm(alarm), .done(done)
  );

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_sharp();
    sharp = 1'b1; cycles(1); sharp = 1'b0;
  endtask

  task automatic pulse_star();
    star = 1'b1; cycles(1); star = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] t);
    {iHour10, iHour1, iMinute10, iMinute1, iSecond10, iSecond1} = t;
    load = 1'b1; cycles(1); load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; sharp = 1'b0; star = 1'b0; load = 1'b0; keypad = '0;
    {iHour10, iHour1, iMinute10, iMinute1, iSecond10, iSecond1} = '0;
    cycles(2);
    tests++;
    if ({time_out, setup_en, running, alarm, done} !== 28'h0) begin
      failed++; $display("FAIL reset_outputs got=%h exp=%h", {time_out, setup_en, running, alarm, done}, 28'h0);
    end
    reset = 1'b0; en = 1'b1;
    cycles(1);
  endtask

  task automatic test_countdown();
    pulse_sharp();
    tests++;
    if (setup_en !== 1'b1) begin failed++; $display("FAIL setup_en_on got=%b exp=1", setup_en); end
    do_load(24'h000003);
    tests++;
    if ({setup_en, running, time_out} !== {2'b01, 24'h000003}) begin
      failed++; $display("FAIL load_to_run got=%h exp=%h", {setup_en, running, time_out}, {2'b01, 24'h000003});
    end
    cycles(3);
    tests++;
    if (time_out !== 24'h000003) begin failed++; $display("FAIL pre_tick1 got=%h exp=000003", time_out); end
    cycles(1);
    tests++;
    if (time_out !== 24'h000002) begin failed++; $display("FAIL tick1 got=%h exp=000002", time_out); end
    cycles(4);
    tests++;
    if (time_out !== 24'h000001) begin failed++; $display("FAIL tick2 got=%h exp=000001", time_out); end
    cycles(3);
    tests++;
    if (done !== 1'b0) begin failed++; $display("FAIL done_early got=%b exp=0", done); end
    cycles(1);
    tests++;
    if ({done, alarm, running, time_out} !== {3'b110, 24'h000000}) begin
      failed++; $display("FAIL tick3_done got=%h exp=%h", {done, alarm, running, time_out}, {3'b110, 24'h0});
    end
  endtask

  task automatic test_alarm_expiry();
    cycles(1);
    tests++;
    if ({done, alarm} !== 2'b01) begin failed++; $display("FAIL done_one_cycle got=%b exp=01", {done, alarm}); end
    cycles(118);
    tests++;
    if (alarm !== 1'b1) begin failed++; $display("FAIL alarm_held_29_ticks got=%b exp=1", alarm); end
    cycles(1);
    tests++;
    if ({alarm, running, setup_en} !== 3'b000) begin
      failed++; $display("FAIL alarm_expiry got=%b exp=000", {alarm, running, setup_en});
    end
  endtask

  task automatic test_borrow();
    pulse_sharp(); do_load(24'h010000); cycles(4);
    tests++;
    if (time_out !== 24'h005959) begin failed++; $display("FAIL borrow_hour got=%h exp=005959", time_out); end
    pulse_star();
    tests++;
    if ({running, time_out} !== 25'h0) begin failed++; $display("FAIL star_run got=%h exp=0", {running, time_out}); end
    pulse_sharp(); do_load(24'h100000); cycles(4);
    tests++;
    if (time_out !== 24'h095959) begin failed++; $display("FAIL borrow_h10 got=%h exp=095959", time_out); end
    pulse_star();
  endtask

  task automatic test_pause();
    pulse_sharp(); do_load(24'h000005); cycles(2);
    pulse_sharp();
    tests++;
    if ({running, time_out} !== {1'b0, 24'h000005}) begin
      failed++; $display("FAIL pause_enter got=%h exp=%h", {running, time_out}, {1'b0, 24'h000005});
    end
    cycles(20);
    tests++;
    if ({running, time_out} !== {1'b0, 24'h000005}) begin
      failed++; $display("FAIL pause_frozen got=%h exp=%h", {running, time_out}, {1'b0, 24'h000005});
    end
    pulse_sharp();
    tests++;
    if ({running, time_out} !== {1'b1, 24'h000005}) begin
      failed++; $display("FAIL resume got=%h exp=%h", {running, time_out}, {1'b1, 24'h000005});
    end
    cycles(1);
    tests++;
    if (time_out !== 24'h000004) begin failed++; $display("FAIL resume_partial_tick got=%h exp=000004", time_out); end
    pulse_star();
  endtask

  task automatic test_invalid_load();
    pulse_sharp();
    do_load(24'h000070);
    tests++;
    if ({setup_en, running, time_out} !== {2'b10, 24'h0}) begin
      failed++; $display("FAIL bad_s10 got=%h exp=%h", {setup_en, running, time_out}, {2'b10, 24'h0});
    end
    do_load(24'h006000);
    tests++;
    if ({setup_en, running, time_out} !== {2'b10, 24'h0}) begin
      failed++; $display("FAIL bad_m10 got=%h exp=%h", {setup_en, running, time_out}, {2'b10, 24'h0});
    end
    do_load(24'h000000);
    tests++;
    if ({setup_en, running, time_out} !== {2'b10, 24'h0}) begin
      failed++; $display("FAIL zero_load got=%h exp=%h", {setup_en, running, time_out}, {2'b10, 24'h0});
    end
  endtask

  task automatic test_snooze();
    do_load(24'h000001); cycles(4);
    tests++;
    if ({alarm, done} !== 2'b11) begin failed++; $display("FAIL snooze_alarm_on got=%b exp=11", {alarm, done}); end
    keypad = 10'b0000001000; cycles(1); keypad = '0;
    tests++;
    if (alarm !== 1'b1) begin failed++; $display("FAIL other_key_ignored got=%b exp=1", alarm); end
    keypad = 10'b0000000001; cycles(1); keypad = '0;
    tests++;
    if ({alarm, running, time_out} !== {2'b01, 24'h000500}) begin
      failed++; $display("FAIL snooze got=%h exp=%h", {alarm, running, time_out}, {2'b01, 24'h000500});
    end
  endtask

  task automatic test_back_to_back();
    star = 1'b1; sharp = 1'b1; cycles(1); star = 1'b0; sharp = 1'b0;
    tests++;
    if ({setup_en, running, time_out} !== 26'h0) begin
      failed++; $display("FAIL star_sharp got=%h exp=0", {setup_en, running, time_out});
    end
    pulse_sharp(); do_load(24'h000009); pulse_sharp();
    en = 1'b0; cycles(1);
    tests++;
    if ({setup_en, running, alarm, done, time_out} !== 28'h0) begin
      failed++; $display("FAIL en_low_pause got=%h exp=0", {setup_en, running, alarm, done, time_out});
    end
    en = 1'b1; cycles(1);
    pulse_sharp(); do_load(24'h000009); cycles(2);
    reset = 1'b1; cycles(1); reset = 1'b0;
    tests++;
    if ({setup_en, running, alarm, done, time_out} !== 28'h0) begin
      failed++; $display("FAIL reset_mid_run got=%h exp=0", {setup_en, running, alarm, done, time_out});
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_alarm_expiry();
    test_borrow();
    test_pause();
    test_invalid_load();
    test_snooze();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
